csr_bus_arbiter: RTL

- Shares the single control-register bus port (active-low ce/we, 4-bit byte mask, 7-bit address, 32-bit data, fixed read latency) between NUM_REQ requesters, e.g. the load/store unit and the debug unit.
- Round-robin grant, at most one transaction per cycle.
- Read responses are returned tagged with the requester id.
- Holds back accesses to the SPI and GPIO registers while the IO side is busy, so a second transfer cannot start before the first one completes.

---
 rtl/csr_pkg.sv | 25 ++
 rtl/csr_bus_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/csr_bus_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR bus constants, request type and IO address decode
package csr_pkg;

    typedef enum logic [4:0] {
        CSR_ADDR_SPI     = 5'd4,
        CSR_ADDR_GPIO    = 5'd5,
        CSR_ADDR_GPIO_IN = 5'd7
    } csr_addr_e;

    localparam int CSR_ADDR_64BIT_BIT = 5;

    typedef struct packed {
        logic        we;
        logic [3:0]  wm;
        logic [6:0]  addr;
        logic [31:0] data;
    } CsrReq;

    // SPI and GPIO live in the low (32-bit) register page; bit 6 is not decoded.
    function automatic logic is_io_access(input logic [6:0] addr);
        return !addr[CSR_ADDR_64BIT_BIT] &&
               (addr[4:0] == CSR_ADDR_SPI || addr[4:0] == CSR_ADDR_GPIO);
    endfunction

endpackage

// File: rtl/csr_bus_arbiter_if.sv
// rtl/csr_bus_arbiter_if.sv - requester and CSR bus signals of the arbiter
interface csr_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       IN_reqValid;
    logic [NUM_REQ-1:0]       IN_reqWe;
    logic [NUM_REQ-1:0][3:0]  IN_reqWm;
    logic [NUM_REQ-1:0][6:0]  IN_reqAddr;
    logic [NUM_REQ-1:0][31:0] IN_reqData;
    logic [NUM_REQ-1:0]       OUT_reqReady;
    logic                     OUT_rspValid;
    logic [ID_W-1:0]          OUT_rspId;
    logic [31:0]              OUT_rspData;
    logic                     OUT_csrCe;
    logic                     OUT_csrWe;
    logic [3:0]               OUT_csrWm;
    logic [6:0]               OUT_csrAddr;
    logic [31:0]              OUT_csrData;
    logic [31:0]              IN_csrData;
    logic                     IN_ioBusy;

    modport slave (
        input  IN_reqValid, IN_reqWe, IN_reqWm, IN_reqAddr, IN_reqData,
        input  IN_csrData, IN_ioBusy,
        output OUT_reqReady, OUT_rspValid, OUT_rspId, OUT_rspData,
        output OUT_csrCe, OUT_csrWe, OUT_csrWm, OUT_csrAddr, OUT_csrData
    );

    modport master (
        output IN_reqValid, IN_reqWe, IN_reqWm, IN_reqAddr, IN_reqData,
        output IN_csrData, IN_ioBusy,
        input  OUT_reqReady, OUT_rspValid, OUT_rspId, OUT_rspData,
        input  OUT_csrCe, OUT_csrWe, OUT_csrWm, OUT_csrAddr, OUT_csrData
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter, search starts after last winner
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                ptr_d        = IDX_W'(idx);
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// rtl/csr_bus_arbiter.sv - shares the CSR bus between requesters, holds back SPI/GPIO while IO is busy
module csr_bus_arbiter
    import csr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 2,
    parameter int IO_LAT  = 2
) (
    input logic              clk,
    input logic              rst,
    csr_bus_arbiter_if.slave bus
);
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(IO_LAT + 1);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    CsrReq              gnt_req;

    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;

    logic               ce_q;
    logic               we_q;
    logic [3:0]         wm_q;
    logic [6:0]         addr_q;
    logic [31:0]        data_q;
    logic [ID_W-1:0]    id_q;

    logic               pipe_vld_q [RD_LAT];
    logic [ID_W-1:0]    pipe_id_q  [RD_LAT];

    // Nothing is granted while in reset so no stale access lands on the bus.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.IN_reqValid[i] && !rst &&
                          !(is_io_access(bus.IN_reqAddr[i]) && (bus.IN_ioBusy || hold_q != '0));
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   (eligible),
        .grant_o (grant)
    );

    always_comb begin
        gnt_req = '0;
        gnt_id  = '0;
        gnt_any = |grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id       = ID_W'(i);
                gnt_req.we   = bus.IN_reqWe[i];
                gnt_req.wm   = bus.IN_reqWm[i];
                gnt_req.addr = bus.IN_reqAddr[i];
                gnt_req.data = bus.IN_reqData[i];
            end
        end
    end

    // ioHold bridges the cycles before the IO block raises its own busy flag.
    always_comb begin
        hold_d = hold_q;
        if (gnt_any && gnt_req.we && is_io_access(gnt_req.addr)) begin
            hold_d = HOLD_W'(IO_LAT);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q   <= 1'b1;
            we_q   <= 1'b1;
            wm_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            id_q   <= '0;
            hold_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_id_q[k]  <= '0;
            end
        end else begin
            ce_q   <= !gnt_any;
            we_q   <= !gnt_req.we;
            wm_q   <= gnt_req.wm;
            addr_q <= gnt_req.addr;
            data_q <= gnt_req.data;
            id_q   <= gnt_id;
            hold_q <= hold_d;
            // Stage 0 captures the read while it is on the bus.
            pipe_vld_q[0] <= !ce_q && we_q;
            pipe_id_q[0]  <= id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
            end
        end
    end

    assign bus.OUT_reqReady = grant;
    assign bus.OUT_csrCe    = ce_q;
    assign bus.OUT_csrWe    = we_q;
    assign bus.OUT_csrWm    = wm_q;
    assign bus.OUT_csrAddr  = addr_q;
    assign bus.OUT_csrData  = data_q;
    assign bus.OUT_rspValid = pipe_vld_q[RD_LAT-1];
    assign bus.OUT_rspId    = pipe_id_q[RD_LAT-1];
    assign bus.OUT_rspData  = bus.IN_csrData;

endmodule
